dna_revcomp_stream: RTL and testbench
=====================================

# dna_revcomp_stream

Streaming reverse / complement engine for 2-bit DNA digits (0=A, 1=C, 2=G, 3=T). It accepts one word of 1..MAX_N digits serially over a valid/ready input. It buffers the word, then re-emits it serially in forward or reversed order, optionally complemented. It is the sequential, variable-length successor to the fixed-width combinational word reverser and sits between the digit-stream parser and the sequence-matching stages.

## Interface
Parameters:
- MAX_N, 16, maximum digits per word (≥2).
- LEN_W, $clog2(MAX_N+1), width of the length output (derived; not to be overridden).

Ports (clock and reset first):
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- mode  in  2  bit0 = reverse, bit1 = complement. 00 pass, 01 reverse, 10 complement, 11 reverse-complement.
- in_valid  in  1  input digit valid.
- in_ready  out  1  block can accept a digit.
- in_digit  in  2  input digit.
- in_last  in  1  final digit of the word.
- out_valid  out  1  output digit valid.
- out_ready  in  1  downstream accepts the digit.
- out_digit  out  2  output digit.
- out_last  out  1  final digit of the output word.
- out_len  out  LEN_W  digit count of the word being drained.
- err_overflow  out  1  one-cycle pulse when a word is truncated at MAX_N.

## Operation
- Two states, LOAD and DRAIN. Reset state is LOAD.
- LOAD:
  - in_ready=1 and out_valid=0.
  - Each handshake (in_valid & in_ready) writes in_digit to buf[wr_cnt] and increments wr_cnt.
  - mode is latched on the first accepted digit of a word. Later mode changes do not affect that word.
  - Accepting a digit with in_last=1 moves the block to DRAIN.
  - Accepting the MAX_N-th digit with in_last=0 also moves the block to DRAIN and pulses err_overflow. Subsequent digits belong to the next word.
- DRAIN:
  - in_ready=0 and out_valid=1.
  - Read index is wr_cnt-1-rd_cnt if reverse is set, else rd_cnt.
  - out_digit = buf[index], bitwise-inverted if complement is set (0↔3, 1↔2).
  - out_last=1 when rd_cnt==wr_cnt-1.
  - out_len=wr_cnt, held stable throughout DRAIN.
  - Each output handshake increments rd_cnt.
  - The handshake with out_last returns the block to LOAD and clears both counters.
- No overlap: a new word is not accepted until the previous word has fully drained.
- Once asserted, out_valid stays high and out_digit/out_last stay stable until out_ready.

## Timing
- Reset values:
  - in_ready=1.
  - out_valid=0, out_digit=0, out_last=0, out_len=0, err_overflow=0.
  - Counters=0, latched mode=00. Buffer contents are don't-care.
- Latency: the first output digit is valid in the cycle after the last input handshake. The minimum turnaround for an N-digit word is N input cycles plus N output cycles.
- Throughput is one digit per cycle in each phase.
- in_ready is a pure function of state. It never depends on in_valid combinationally.
- out_valid has no combinational dependency on out_ready.
- Single-digit word (in_last on the first digit): DRAIN emits one digit with out_last=1 and out_len=1.
- err_overflow asserts in the cycle after the MAX_N-th handshake, together with the first out_valid.
- Back-to-back words:
  - in_ready returns high in the cycle after the final output handshake.
  - A digit presented in that cycle is accepted.
- Asynchronous rst mid-LOAD or mid-DRAIN aborts the word immediately. All outputs return to reset values, and no partial output follows.

## Structure
- Package dna_pkg:
  - typedef digit_t (logic [1:0]).
  - Enum constants A/C/G/T.
  - typedef state_e {LOAD, DRAIN}.
  - Function comp_digit() (bitwise inversion).
- One natural sub-module: dna_digit_buf. It is a MAX_N×2-bit register file with a synchronous write port and an asynchronous read port, indexed by the reverse mux.
- Counter, state machine and mode latch live in the top.

## Test plan
- Word [1,0,0,2], mode 01, out_ready=1 → output 2,0,0,1. out_last on the 4th digit, out_len=4.
- Word [2,0,1,3], mode 11 → output 0,2,3,1. With mode 00 → 2,0,1,3. With mode 10 → 1,3,2,0.
- Word [3,1,2,2], mode 01, out_ready toggled 1,0,0,1,… → output 2,2,1,3. out_digit stays stable while stalled. No digit is dropped or duplicated.
- MAX_N=4: five digits [0,1,2,3,0] with no in_last, mode 01:
  - err_overflow pulses once and the output is 3,2,1,0.
  - The fifth digit, 0, starts the next word. With in_last on it, the next word outputs a single 0.
- mode changed from 01 to 00 mid-load of [1,0,0,2] → output still 2,0,0,1. A single-digit word [3], mode 10 → output 0, out_last=1, out_len=1.
- rst asserted during the 2nd DRAIN cycle of a 4-digit word:
  - Outputs are at reset values immediately.
  - After release, word [1,2], mode 01, yields 2,1.

Source files
------------

// File: rtl/dna_pkg.sv
// Shared types and helpers for the 2-bit DNA digit streaming blocks.
// Digit encoding: A=0, C=1, G=2, T=3, so complementing a digit is a bitwise inversion.
package dna_pkg;

    typedef logic [1:0] digit_t;

    typedef enum logic [1:0] {
        A = 2'd0,
        C = 2'd1,
        G = 2'd2,
        T = 2'd3
    } base_e;

    typedef enum logic {
        LOAD  = 1'b0,
        DRAIN = 1'b1
    } state_e;

    // Bit positions inside the 2-bit mode word
    localparam int MODE_REV  = 0;
    localparam int MODE_COMP = 1;

    function automatic digit_t comp_digit(input digit_t d);
        return ~d;
    endfunction

endpackage

// File: rtl/dna_digit_buf.sv
// MAX_N x 2-bit register file: synchronous write, asynchronous read.
// Contents are deliberately not reset; only the counters define which entries are meaningful.
module dna_digit_buf
    import dna_pkg::*;
#(
    parameter int MAX_N = 16,
    parameter int IDX_W = (MAX_N > 1) ? $clog2(MAX_N) : 1
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  digit_t           wr_data,
    input  logic [IDX_W-1:0] rd_addr,
    output digit_t           rd_data
);

    digit_t mem_q [MAX_N];
    digit_t mem_d [MAX_N];

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/dna_revcomp_stream.sv
// Streaming reverse / complement engine: buffers one word of 1..MAX_N digits,
// then re-emits it forward or reversed, optionally complemented.
module dna_revcomp_stream
    import dna_pkg::*;
#(
    parameter int MAX_N = 16,
    parameter int LEN_W = $clog2(MAX_N + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_digit,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_digit,
    output logic             out_last,
    output logic [LEN_W-1:0] out_len,
    output logic             err_overflow
);

    localparam int IDX_W = (MAX_N > 1) ? $clog2(MAX_N) : 1;
    localparam logic [LEN_W-1:0] LAST_SLOT = LEN_W'(MAX_N - 1);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [LEN_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [1:0]       mode_q, mode_d;
    logic             err_q, err_d;

    logic             in_fire;
    logic             out_fire;
    logic             wr_full;
    logic             drain_last;
    logic [IDX_W-1:0] rd_idx;
    digit_t           rd_data;

    assign in_fire    = in_valid & in_ready;
    assign out_fire   = out_valid & out_ready;
    assign wr_full    = (wr_cnt_q == LAST_SLOT);
    assign drain_last = (rd_cnt_q == wr_cnt_q - LEN_W'(1));

    always_comb begin
        if (mode_q[MODE_REV]) begin
            rd_idx = IDX_W'(wr_cnt_q - LEN_W'(1) - rd_cnt_q);
        end else begin
            rd_idx = IDX_W'(rd_cnt_q);
        end
    end

    dna_digit_buf #(
        .MAX_N (MAX_N),
        .IDX_W (IDX_W)
    ) u_buf (
        .clk     (clk),
        .wr_en   (in_fire),
        .wr_addr (IDX_W'(wr_cnt_q)),
        .wr_data (in_digit),
        .rd_addr (rd_idx),
        .rd_data (rd_data)
    );

    // State register plus the counters, mode latch and overflow pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= LOAD;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            mode_q   <= 2'b00;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            mode_q   <= mode_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD: begin
                if (in_fire && (in_last || wr_full)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (out_fire && drain_last) begin
                    state_d = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_comb begin
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        mode_d   = mode_q;
        err_d    = 1'b0;
        if (in_fire) begin
            wr_cnt_d = wr_cnt_q + LEN_W'(1);
            // Mode is captured only with the first digit so a word is processed consistently
            if (wr_cnt_q == '0) begin
                mode_d = mode;
            end
            if (wr_full && !in_last) begin
                err_d = 1'b1;
            end
        end
        if (out_fire) begin
            if (drain_last) begin
                wr_cnt_d = '0;
                rd_cnt_d = '0;
            end else begin
                rd_cnt_d = rd_cnt_q + LEN_W'(1);
            end
        end
    end

    always_comb begin
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        out_digit    = 2'b00;
        out_last     = 1'b0;
        out_len      = wr_cnt_q;
        err_overflow = err_q;
        case (state_q)
            LOAD: begin
                in_ready = 1'b1;
            end
            DRAIN: begin
                out_valid = 1'b1;
                out_digit = mode_q[MODE_COMP] ? comp_digit(rd_data) : rd_data;
                out_last  = drain_last;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_dna_revcomp_stream.sv
// Directed bench for dna_revcomp_stream (MAX_N=4 so the overflow path is reachable
// with short words). Inputs are driven and outputs sampled 1ns after the rising edge.
module tb_dna_revcomp_stream;

    localparam int MAX_N = 4;
    localparam int LEN_W = $clog2(MAX_N + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       mode;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_digit;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       out_digit;
    logic             out_last;
    logic [LEN_W-1:0] out_len;
    logic             err_overflow;

    int n_cmp  = 0;
    int n_fail = 0;
    int err_pulses = 0;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (err_overflow === 1'b1) err_pulses++;
    end

    dna_revcomp_stream #(.MAX_N(MAX_N)) dut (
        .clk          (clk),
        .rst          (rst),
        .mode         (mode),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_digit     (in_digit),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_digit    (out_digit),
        .out_last     (out_last),
        .out_len      (out_len),
        .err_overflow (err_overflow)
    );

    // Digit i of a word lives at bits [2i+1:2i]
    function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
        logic [31:0] w;
        w = '0;
        w[1:0] = 2'(a);
        w[3:2] = 2'(b);
        w[5:4] = 2'(c);
        w[7:6] = 2'(d);
        return w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pushes n digits; first digit carries m_first, the rest m_rest. in_last on the final one if set_last.
    task automatic load_word(input logic [31:0] w, input int n, input logic [1:0] m_first,
                             input logic [1:0] m_rest, input bit set_last);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_digit = w[2*i +: 2];
            in_last  = set_last && (i == n - 1);
            mode     = (i == 0) ? m_first : m_rest;
            step();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Drains n digits; stall=1 drives out_ready with the pattern 1,0,0,1,0,0,...
    task automatic drain_check(input string name, input logic [31:0] e, input int n,
                               input int len, input bit stall);
        int got;
        int cyc;
        logic exp_last;
        got = 0;
        cyc = 0;
        while (got < n && cyc < 60) begin
            out_ready = stall ? (cyc % 3 == 0) : 1'b1;
            n_cmp++;
            if (out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL %s valid[%0d]: got %b want 1", name, got, out_valid);
            end else begin
                exp_last = (got == n - 1);
                n_cmp++;
                if (out_digit !== e[2*got +: 2]) begin
                    n_fail++;
                    $display("FAIL %s digit[%0d]: got %0d want %0d", name, got, out_digit, e[2*got +: 2]);
                end
                n_cmp++;
                if (out_last !== exp_last) begin
                    n_fail++;
                    $display("FAIL %s last[%0d]: got %b want %b", name, got, out_last, exp_last);
                end
                n_cmp++;
                if (out_len !== LEN_W'(len)) begin
                    n_fail++;
                    $display("FAIL %s len[%0d]: got %0d want %0d", name, got, out_len, len);
                end
                if (out_ready) got++;
            end
            step();
            cyc++;
        end
        out_ready = 1'b0;
        n_cmp++;
        if (got != n) begin
            n_fail++;
            $display("FAIL %s count: got %0d want %0d digits", name, got, n);
        end
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s back_to_load: out_valid=%b in_ready=%b want 0/1", name, out_valid, in_ready);
        end
    endtask

    task automatic check_idle(input string name);
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_digit !== 2'd0 || out_last !== 1'b0 ||
            out_len !== '0 || err_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: rdy=%b vld=%b dig=%0d last=%b len=%0d err=%b want 1 0 0 0 0 0",
                     name, in_ready, out_valid, out_digit, out_last, out_len, err_overflow);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        check_idle("reset_state");
        rst = 1'b0;
        step();
        check_idle("after_release");
    endtask

    task automatic test_reverse();
        load_word(pk(1, 0, 0, 2), 4, 2'b01, 2'b01, 1'b1);
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL latency: out_valid got %b want 1 right after last input", out_valid);
        end
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_in_ready: got %b want 0", in_ready);
        end
        drain_check("rev", pk(2, 0, 0, 1), 4, 4, 1'b0);
    endtask

    task automatic test_modes();
        load_word(pk(2, 0, 1, 3), 4, 2'b11, 2'b11, 1'b1);
        drain_check("revcomp", pk(0, 2, 3, 1), 4, 4, 1'b0);
        load_word(pk(2, 0, 1, 3), 4, 2'b00, 2'b00, 1'b1);
        drain_check("pass", pk(2, 0, 1, 3), 4, 4, 1'b0);
        load_word(pk(2, 0, 1, 3), 4, 2'b10, 2'b10, 1'b1);
        drain_check("comp", pk(1, 3, 2, 0), 4, 4, 1'b0);
    endtask

    task automatic test_stall();
        load_word(pk(3, 1, 2, 2), 4, 2'b01, 2'b01, 1'b1);
        drain_check("stall", pk(2, 2, 1, 3), 4, 4, 1'b1);
    endtask

    task automatic test_overflow();
        int p0;
        p0 = err_pulses;
        load_word(pk(0, 1, 2, 3), 4, 2'b01, 2'b01, 1'b0);
        n_cmp++;
        if (err_overflow !== 1'b1 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_pulse: err=%b vld=%b want 1/1", err_overflow, out_valid);
        end
        // Fifth digit waits on the input while the truncated word drains
        in_valid = 1'b1;
        in_digit = 2'd0;
        in_last  = 1'b1;
        mode     = 2'b01;
        drain_check("ovf_word", pk(3, 2, 1, 0), 4, 4, 1'b0);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        drain_check("ovf_next", pk(0, 0, 0, 0), 1, 1, 1'b0);
        n_cmp++;
        if (err_pulses - p0 != 1) begin
            n_fail++;
            $display("FAIL ovf_count: got %0d pulses want 1", err_pulses - p0);
        end
    endtask

    task automatic test_mode_latch_single();
        load_word(pk(1, 0, 0, 2), 4, 2'b01, 2'b00, 1'b1);
        drain_check("mode_latch", pk(2, 0, 0, 1), 4, 4, 1'b0);
        load_word(pk(3, 0, 0, 0), 1, 2'b10, 2'b10, 1'b1);
        drain_check("single", pk(0, 0, 0, 0), 1, 1, 1'b0);
    endtask

    task automatic test_reset_mid_drain();
        load_word(pk(1, 2, 3, 0), 4, 2'b01, 2'b01, 1'b1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        rst = 1'b1;
        #1;
        check_idle("rst_mid_drain");
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_idle("no_partial_output");
        end
        load_word(pk(1, 2, 0, 0), 2, 2'b01, 2'b01, 1'b1);
        drain_check("after_rst", pk(2, 1, 0, 0), 2, 2, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        mode      = 2'b00;
        in_valid  = 1'b0;
        in_digit  = 2'd0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        #1;
        test_reset();
        test_reverse();
        test_modes();
        test_stall();
        test_overflow();
        test_mode_latch_single();
        test_reset_mid_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
